// File: rtl/sqrt_seq_ctrl.sv
// Sequencer for the iterative integer square-root datapath. An EVAL happens every SETTLE_CYC+1 cycles after accept.
// The result is held in DONE until res_ready_i. req_ready_o is high only in IDLE, and clear_i aborts to IDLE from any state.
module sqrt_seq_ctrl #(
   parameter int SETTLE_CYC = 1,
   parameter int ROOT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              clear_i,
   input  logic              le_i,
   output logic              wr_input_o,
   output logic              wr_root_o,
   output logic              en_pipe_o,
   output logic              init_sel_o,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic              busy_o,
   output logic [ROOT_W-1:0] iter_cnt_o,
   output logic              ovf_o
);

   localparam int                CNT_W         = 4;
   localparam logic [CNT_W-1:0]  SETTLE_RELOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [ROOT_W-1:0] ITER_MAX      = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      EVAL   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ROOT_W-1:0]  iter_q, iter_d;
   logic               ovf_q, ovf_d;

   logic req_ready, wr_input, wr_root, en_pipe, init_sel, res_valid, busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         iter_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      iter_d    = iter_q;
      ovf_d     = ovf_q;
      req_ready = 1'b0;
      wr_input  = 1'b0;
      wr_root   = 1'b0;
      en_pipe   = 1'b0;
      init_sel  = 1'b0;
      res_valid = 1'b0;
      busy      = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid_i) begin
               wr_input = 1'b1;
               wr_root  = 1'b1;
               en_pipe  = 1'b1;
               init_sel = 1'b1;
               iter_d   = '0;
               ovf_d    = 1'b0;
               cnt_d    = SETTLE_RELOAD;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = EVAL;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         EVAL: begin
            if (le_i) begin
               if (iter_q != ITER_MAX) begin
                  wr_root = 1'b1;
                  en_pipe = 1'b1;
                  iter_d  = iter_q + ROOT_W'(1);
                  cnt_d   = SETTLE_RELOAD;
                  state_d = SETTLE;
               end else begin
                  // Guard only reachable with a faulty datapath: root cannot exceed ITER_MAX.
                  ovf_d   = 1'b1;
                  state_d = DONE;
               end
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over accept and over a DONE transfer; result registers are left intact.
      if (clear_i) begin
         state_d  = IDLE;
         cnt_d    = cnt_q;
         iter_d   = iter_q;
         ovf_d    = ovf_q;
         wr_input = 1'b0;
         wr_root  = 1'b0;
         en_pipe  = 1'b0;
         init_sel = 1'b0;
      end
   end

   assign req_ready_o = req_ready & rst_n;
   assign wr_input_o  = wr_input & rst_n;
   assign wr_root_o   = wr_root & rst_n;
   assign en_pipe_o   = en_pipe & rst_n;
   assign init_sel_o  = init_sel & rst_n;
   assign res_valid_o = res_valid & rst_n;
   assign busy_o      = busy & rst_n;
   assign iter_cnt_o  = rst_n ? iter_q : '0;
   assign ovf_o       = ovf_q & rst_n;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed plus randomized bench for sqrt_seq_ctrl with a behavioural square-root datapath and reference model.
module tb_sqrt_seq_ctrl;

   localparam int S      = 1;
   localparam int ROOT_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              clear = 1'b0;
   logic              le;
   logic              wr_input, wr_root, en_pipe, init_sel;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic              busy;
   logic [ROOT_W-1:0] iter_cnt;
   logic              ovf;

   logic [15:0] dp_in = 16'd0;
   logic [15:0] in_r = 16'd0;
   logic [16:0] sq_r = 17'd0;
   logic [7:0]  root_r = 8'd0;
   logic        force_le = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sqrt_seq_ctrl #(.SETTLE_CYC(S), .ROOT_W(ROOT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .clear_i    (clear),
      .le_i       (le),
      .wr_input_o (wr_input),
      .wr_root_o  (wr_root),
      .en_pipe_o  (en_pipe),
      .init_sel_o (init_sel),
      .res_valid_o(res_valid),
      .res_ready_i(res_ready),
      .busy_o     (busy),
      .iter_cnt_o (iter_cnt),
      .ovf_o      (ovf)
   );

   // Datapath: input, square and root registers with a combinational compare.
   always @(posedge clk) begin
      if (wr_input) in_r <= dp_in;
      if (wr_root)  root_r <= init_sel ? 8'd0 : root_r + 8'd1;
      if (en_pipe)  sq_r <= init_sel ? 17'd1 : sq_r + {8'd0, root_r, 1'b0} + 17'd3;
   end
   assign le = force_le | (sq_r <= {1'b0, in_r});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int isqrt(input int n);
      int r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an operand in the current cycle and check the accept strobes.
   task automatic start_op(input int n);
      req_valid = 1'b1;
      dp_in     = 16'(n);
      @(negedge clk);
      check("acc_ready", req_ready, 1);
      check("acc_strobes", {wr_input, wr_root, en_pipe, init_sel}, 4'b1111);
      step();
      req_valid = 1'b0;
   endtask

   task automatic run_op(input int n, input bit frc, input int stall);
      int  exp_r, exp_cyc, c, pulses;
      bit  got, bad_wi, bad_pulse;
      exp_r     = frc ? 255 : isqrt(n);
      exp_cyc   = (exp_r + 1) * (S + 1) + 1;
      force_le  = frc;
      pulses    = 0;
      got       = 1'b0;
      bad_wi    = 1'b0;
      bad_pulse = 1'b0;
      c         = 1;
      step();
      start_op(n);
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (res_valid) begin
            got = 1'b1;
         end else begin
            if (wr_input) bad_wi = 1'b1;
            if (wr_root) begin
               pulses++;
               if (c != pulses * (S + 1) || init_sel || !en_pipe) bad_pulse = 1'b1;
            end
            step();
            c++;
         end
      end
      check("res_seen", got, 1);
      check("res_cycle", c, exp_cyc);
      check("pulse_count", pulses, exp_r);
      check("pulse_timing", bad_pulse, 0);
      check("wr_input_midop", bad_wi, 0);
      check("res_iter", iter_cnt, exp_r);
      check("res_ovf", ovf, frc);
      check("done_strobes", {wr_input, wr_root, en_pipe}, 0);
      force_le = 1'b0;
      for (int i = 0; i < stall; i++) begin
         step();
         @(negedge clk);
         check("stall_valid", res_valid, 1);
         check("stall_strobes", {wr_input, wr_root, en_pipe}, 0);
      end
      step();
      res_ready = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      check("xfer_valid", res_valid, 1);
      check("bubble_no_accept", {req_ready, wr_input}, 0);
      step();
      res_ready = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("post_idle", {res_valid, busy, req_ready}, 3'b001);
      check("post_iter_hold", iter_cnt, exp_r);
      check("post_ovf_hold", ovf, frc);
   endtask

   initial begin
      int n;
      // Reset with a request pending: every output must be low.
      req_valid = 1'b1;
      dp_in     = 16'd5;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_outputs",
               {req_ready, wr_input, wr_root, en_pipe, init_sel, res_valid, busy, ovf, iter_cnt}, 0);
         step();
      end
      rst_n     = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_release_ready", req_ready, 1);
      check("rst_release_busy", busy, 0);
      check("rst_release_iter", iter_cnt, 0);

      run_op(0, 1'b0, 0);
      run_op(16, 1'b0, 5);
      run_op(65535, 1'b0, 1);
      run_op(1234, 1'b1, 2);
      for (int k = 0; k < 4; k++) begin
         n = int'($urandom_range(0, 65535));
         run_op(n, 1'b0, int'($urandom_range(0, 3)));
      end
      for (int k = 0; k < 4; k++) begin
         n = int'($urandom_range(0, 300));
         run_op(n, 1'b0, int'($urandom_range(0, 3)));
      end

      // Abort in SETTLE after one increment.
      step();
      start_op(100);
      step();
      step();
      clear = 1'b1;
      @(negedge clk);
      check("clr_strobes", {wr_input, wr_root, en_pipe, init_sel}, 0);
      check("clr_busy_before", busy, 1);
      step();
      clear = 1'b0;
      @(negedge clk);
      check("clr_idle", {busy, req_ready}, 2'b01);
      check("clr_iter_hold", iter_cnt, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         check("clr_no_writes", {wr_input, wr_root, en_pipe, busy}, 0);
      end

      // Abort beats an accept in IDLE.
      step();
      clear     = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      check("clr_vs_accept", {wr_input, wr_root, en_pipe}, 0);
      step();
      clear     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("clr_vs_accept_idle", busy, 0);

      // Reset during the second EVAL.
      step();
      start_op(100);
      step();
      step();
      step();
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs",
            {req_ready, wr_input, wr_root, en_pipe, init_sel, res_valid, busy, ovf, iter_cnt}, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_idle", {busy, req_ready, res_valid}, 3'b010);
      check("rst_mid_iter", iter_cnt, 0);

      run_op(49, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
